// File: rtl/instr_encoder_if.sv
// instr_encoder_if: descriptor input and instruction-word output handshakes of the encoder.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_kind;
  logic [2:0]  in_funct3;
  logic        in_alt;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_illegal;
  modport master (
    output in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_word, out_illegal
  );
  modport slave (
    input  in_valid, in_kind, in_funct3, in_alt, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_word, out_illegal
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: streams RV32I field descriptors into 32-bit instruction words, expanding LI into LUI+ADDI.
module instr_encoder #(
  parameter logic [31:0] NOP_WORD = 32'h00000013
) (
  input logic                clk,
  input logic                rst_n,
  instr_encoder_if.slave     bus
);
  typedef enum logic {IDLE, LI_LO} state_t;
  state_t      state_q, state_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_word_q, out_word_d;
  logic        out_illegal_q, out_illegal_d;
  logic [4:0]  rd_q, rd_d;
  logic [11:0] lo_q, lo_d;
  logic        load;
  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        li_hold;
  logic        li_small;
  logic [19:0] li_hi;
  logic [11:0] i_alu_imm;
  logic [31:0] imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  assign imm       = bus.in_imm;
  assign rd        = bus.in_rd;
  assign rs1       = bus.in_rs1;
  assign rs2       = bus.in_rs2;
  assign f3        = bus.in_funct3;
  assign load      = !out_valid_q || bus.out_ready;
  assign li_small  = (&imm[31:11]) || !(|imm[31:11]);
  assign li_hi     = imm[31:12] + {19'd0, imm[11]};
  assign i_alu_imm = (f3 == 3'b001 || f3 == 3'b101) ? {1'b0, bus.in_alt, 5'b0, imm[4:0]} : imm[11:0];
  assign bus.in_ready    = (state_q == IDLE) && load;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_word    = out_word_q;
  assign bus.out_illegal = out_illegal_q;
  always_comb begin
    enc_word    = NOP_WORD;
    enc_illegal = 1'b0;
    li_hold     = 1'b0;
    case (bus.in_kind)
      4'd0:  enc_word = NOP_WORD;
      4'd1:  enc_word = {1'b0, bus.in_alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
      4'd2:  enc_word = {i_alu_imm, rs1, f3, rd, 7'b0010011};
      4'd3:  enc_word = {imm[11:0], rs1, f3, rd, 7'b0000011};
      4'd4:  enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
      4'd5:  enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      4'd6:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      4'd7:  enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      4'd8:  enc_word = {imm[31:12], rd, 7'b0110111};
      4'd9:  enc_word = {imm[31:12], rd, 7'b0010111};
      4'd10: begin
        // Small values fit one ADDI from x0; otherwise LUI now and ADDI later if lo is nonzero.
        enc_word = li_small ? {imm[11:0], 5'd0, 3'b000, rd, 7'b0010011} : {li_hi, rd, 7'b0110111};
        li_hold  = !li_small && (|imm[11:0]);
      end
      default: enc_illegal = 1'b1;
    endcase
  end
  always_comb begin
    state_d       = state_q;
    out_valid_d   = out_valid_q;
    out_word_d    = out_word_q;
    out_illegal_d = out_illegal_q;
    rd_d          = rd_q;
    lo_d          = lo_q;
    if (load) begin
      out_valid_d = 1'b0;
      if (state_q == LI_LO) begin
        out_valid_d   = 1'b1;
        out_word_d    = {lo_q, rd_q, 3'b000, rd_q, 7'b0010011};
        out_illegal_d = 1'b0;
        state_d       = IDLE;
      end else if (bus.in_valid) begin
        out_valid_d   = 1'b1;
        out_word_d    = enc_word;
        out_illegal_d = enc_illegal;
        if (li_hold) begin
          state_d = LI_LO;
          rd_d    = rd;
          lo_d    = imm[11:0];
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      out_valid_q   <= 1'b0;
      out_word_q    <= 32'd0;
      out_illegal_q <= 1'b0;
      rd_q          <= 5'd0;
      lo_q          <= 12'd0;
    end else begin
      state_q       <= state_d;
      out_valid_q   <= out_valid_d;
      out_word_q    <= out_word_d;
      out_illegal_q <= out_illegal_d;
      rd_q          <= rd_d;
      lo_q          <= lo_d;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenario tasks with hand-computed RV32I words for instr_encoder.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  instr_encoder_if bus ();
  instr_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] kind, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    bus.in_valid  = 1'b1;
    bus.in_kind   = kind;
    bus.in_funct3 = f3;
    bus.in_alt    = alt;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_imm    = imm;
  endtask
  task automatic idle();
    bus.in_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    drive(4'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0);
    idle();
    #12;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_word !== 32'd0) begin bad++; $display("FAIL reset_word got=%h want=00000000", bus.out_word); end
    total++; if (bus.out_illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", bus.out_illegal); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic test_r_alu();
    drive(4'd1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL r_ready0 got=%b want=1", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h002081B3) begin bad++; $display("FAIL r_add got=%b/%h want=1/002081b3", bus.out_valid, bus.out_word); end
    drive(4'd1, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL r_ready1 got=%b want=1", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h402081B3) begin bad++; $display("FAIL r_sub got=%b/%h want=1/402081b3", bus.out_valid, bus.out_word); end
    idle();
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL r_drain got=%b want=0", bus.out_valid); end
  endtask
  task automatic test_formats();
    drive(4'd5, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    step();
    total++; if (bus.out_word !== 32'h00208463) begin bad++; $display("FAIL branch got=%h want=00208463", bus.out_word); end
    drive(4'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0);
    step();
    total++; if (bus.out_word !== 32'h000000EF) begin bad++; $display("FAIL jal got=%h want=000000ef", bus.out_word); end
    drive(4'd2, 3'd5, 1'b1, 5'd3, 5'd1, 5'd0, 32'hFFFFFFE3);
    step();
    total++; if (bus.out_word !== 32'h4030D193) begin bad++; $display("FAIL srai got=%h want=4030d193", bus.out_word); end
    drive(4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
    step();
    total++; if (bus.out_word !== 32'h0020A423) begin bad++; $display("FAIL store got=%h want=0020a423", bus.out_word); end
    idle();
    step();
  endtask
  task automatic test_li_pair();
    drive(4'd10, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    step();
    idle();
    total++; if (bus.out_word !== 32'h123452B7) begin bad++; $display("FAIL li_lui got=%h want=123452b7", bus.out_word); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL li_lo_ready got=%b want=0", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h67828293) begin bad++; $display("FAIL li_addi got=%b/%h want=1/67828293", bus.out_valid, bus.out_word); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL li_ready_back got=%b want=1", bus.in_ready); end
    drive(4'd10, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00000800);
    step();
    idle();
    total++; if (bus.out_word !== 32'h000012B7) begin bad++; $display("FAIL li_carry_lui got=%h want=000012b7", bus.out_word); end
    step();
    total++; if (bus.out_word !== 32'h80028293) begin bad++; $display("FAIL li_carry_addi got=%h want=80028293", bus.out_word); end
    step();
  endtask
  task automatic test_li_single();
    drive(4'd10, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF);
    step();
    total++; if (bus.out_word !== 32'hFFF00293) begin bad++; $display("FAIL li_small got=%h want=fff00293", bus.out_word); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL li_small_ready got=%b want=1", bus.in_ready); end
    drive(4'd10, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h00010000);
    step();
    total++; if (bus.out_word !== 32'h000102B7) begin bad++; $display("FAIL li_lui_only got=%h want=000102b7", bus.out_word); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL li_lui_only_ready got=%b want=1", bus.in_ready); end
    drive(4'd1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    total++; if (bus.out_word !== 32'h002081B3) begin bad++; $display("FAIL li_followup got=%h want=002081b3", bus.out_word); end
    idle();
    step();
  endtask
  task automatic test_back_to_back_backpressure();
    drive(4'd10, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    step();
    idle();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h123452B7 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b want=1/123452b7/0", i, bus.out_valid, bus.out_word, bus.in_ready); end
    end
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b1 || bus.out_word !== 32'h67828293) begin bad++; $display("FAIL bp_addi got=%b/%h want=1/67828293", bus.out_valid, bus.out_word); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", bus.out_valid); end
  endtask
  task automatic test_reset_mid_li();
    drive(4'd10, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345678);
    step();
    idle();
    bus.out_ready = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b want=0", bus.out_valid); end
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_no_addi got=%b want=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b want=1", bus.in_ready); end
    step();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_quiet got=%b want=0", bus.out_valid); end
  endtask
  task automatic test_illegal();
    drive(4'd12, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    total++; if (bus.out_word !== 32'h00000013 || bus.out_illegal !== 1'b1) begin bad++; $display("FAIL illegal got=%h/%b want=00000013/1", bus.out_word, bus.out_illegal); end
    drive(4'd1, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    total++; if (bus.out_word !== 32'h002081B3 || bus.out_illegal !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%h/%b want=002081b3/0", bus.out_word, bus.out_illegal); end
    drive(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    total++; if (bus.out_word !== 32'h00000013 || bus.out_illegal !== 1'b0) begin bad++; $display("FAIL nop got=%h/%b want=00000013/0", bus.out_word, bus.out_illegal); end
    idle();
    step();
  endtask
  initial begin
    test_reset();
    test_r_alu();
    test_formats();
    test_li_pair();
    test_li_single();
    test_back_to_back_backpressure();
    test_reset_mid_li();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
